// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning slice.
//   btn_state_t    : per-button debounce/hold FSM states
//   CLK_HZ         : board clock frequency
//   DEBOUNCE_10MS  : default debounce length (10 ms of CLK_HZ)
//   LONG_1S        : default long-press length (1 s of CLK_HZ)
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    LONG,
    DB_REL
  } btn_state_t;

  localparam int unsigned CLK_HZ        = 27000000;
  localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int unsigned LONG_1S       = CLK_HZ;

endpackage

// File: rtl/btn_debounce_fsm.sv
// Single-button conditioner: 2-flop synchronizer, debounce FSM and hold timer.
//   clk, reset     : system clock, synchronous active-high reset
//   btn_n          : raw active-low button pin (asynchronous)
//   pressed        : debounced level, 1 = held
//   press_pulse    : one-cycle pulse when a press is accepted
//   release_pulse  : one-cycle pulse when a release is accepted
//   long_pulse     : one-cycle pulse when the hold reaches LONG_CYCLES
module btn_debounce_fsm
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  logic s1, s2, p;
  btn_state_t state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic long_q, long_d;
  logic pressed_d, press_d, rel_d, longp_d;

  assign p = ~s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      state_q       <= IDLE;
      dcnt_q        <= '0;
      hcnt_q        <= '0;
      long_q        <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      s1            <= btn_n;
      s2            <= s1;
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      hcnt_q        <= hcnt_d;
      long_q        <= long_d;
      pressed       <= pressed_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      long_pulse    <= longp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    long_d    = long_q;
    pressed_d = pressed;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    longp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pressed_d = 1'b0;
        if (p) begin
          state_d = DB_PRESS;
          dcnt_d  = '0;
        end
      end
      DB_PRESS: begin
        if (!p) begin
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d   = HELD;
          hcnt_d    = '0;
          pressed_d = 1'b1;
          press_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!p) begin
          state_d = DB_REL;
          dcnt_d  = '0;
          long_d  = 1'b0;
        end else if (hcnt_q == H_LAST) begin
          state_d = LONG;
          longp_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      LONG: begin
        if (!p) begin
          state_d = DB_REL;
          dcnt_d  = '0;
          long_d  = 1'b1;
        end
      end
      DB_REL: begin
        pressed_d = 1'b1;
        if (p) begin
          // The returning cycle already counts as held, so a release glitch
          // delays long_pulse by exactly the number of cycles it lasted.
          if (long_q) begin
            state_d = LONG;
          end else if (hcnt_q == H_LAST) begin
            state_d = LONG;
            longp_d = 1'b1;
          end else begin
            state_d = HELD;
            hcnt_d  = hcnt_q + HW'(1);
          end
        end else if (dcnt_q == D_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          rel_d     = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/button_events.sv
// Board push-button front end: one independent conditioner per button.
//   clk, reset     : 27 MHz system clock, synchronous active-high reset
//   btn_n          : raw active-low button pins (asynchronous)
//   pressed        : debounced levels, 1 = held
//   press_pulse    : one-cycle press-accepted pulses
//   release_pulse  : one-cycle release-accepted pulses
//   long_pulse     : one-cycle long-press pulses
module button_events
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_btn (
      .clk          (clk),
      .reset        (reset),
      .btn_n        (btn_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events (N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
module tb_button_events;

  localparam int unsigned N = 2;
  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_n;
  logic [N-1:0] pressed, press_pulse, release_pulse, long_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: raw-pin history, accepted level, disagreement run,
  // held-cycle count and per-button pulse expectations.
  logic [N-1:0] h1, h2;
  logic [N-1:0] m_acc, m_pp, m_rp, m_lp, m_done;
  int m_run[N];
  int m_held[N];

  // Observed pulse bookkeeping taken from DUT outputs.
  int last_press[N], last_rel[N], last_long[N];
  int press_cnt[N], rel_cnt[N], long_cnt[N];

  button_events #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic step();
    logic [N-1:0] raw;
    logic         rst;
    logic [N-1:0] p;
    raw = btn_n;
    rst = reset;
    @(posedge clk);
    cyc++;
    m_pp = '0;
    m_rp = '0;
    m_lp = '0;
    if (rst) begin
      h1     = '1;
      h2     = '1;
      m_acc  = '0;
      m_done = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      p = ~h2;
      for (int i = 0; i < N; i++) begin
        if (p[i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_acc[i] = p[i];
            m_run[i] = 0;
            if (p[i]) begin
              m_pp[i]   = 1'b1;
              m_held[i] = 0;
              m_done[i] = 1'b0;
            end else begin
              m_rp[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
          if (m_acc[i] && !m_done[i]) begin
            m_held[i]++;
            if (m_held[i] == L) begin
              m_lp[i]   = 1'b1;
              m_done[i] = 1'b1;
            end
          end
        end
      end
      h2 = h1;
      h1 = raw;
    end
    #1;
    check("pressed", pressed, m_acc);
    check("press_pulse", press_pulse, m_pp);
    check("release_pulse", release_pulse, m_rp);
    check("long_pulse", long_pulse, m_lp);
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i])   begin last_press[i] = cyc; press_cnt[i]++; end
      if (release_pulse[i]) begin last_rel[i]   = cyc; rel_cnt[i]++;   end
      if (long_pulse[i])    begin last_long[i]  = cyc; long_cnt[i]++;  end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t0;
    int pc, lc, rc;
    int cnt[N];
    btn_n = '1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      last_press[i] = 0; last_rel[i] = 0; last_long[i] = 0;
      cnt[i] = 0;
    end
    steps(2);
    check("reset_outputs", pressed | press_pulse | release_pulse | long_pulse, '0);
    reset = 1'b0;
    steps(3);

    // Clean press on button 0: sampled at edge k, pulse after edge k+6.
    btn_n[0] = 1'b0;
    steps(6);
    check("press_not_early", press_pulse, 2'b00);
    step();
    check("press_on_time", press_pulse, 2'b01);
    step();
    check("pressed_level", pressed, 2'b01);

    // Long hold, then release.
    steps(39);
    check_int("long_delay", last_long[0] - last_press[0], L);
    check_int("long_once", long_cnt[0], 1);
    btn_n[0] = 1'b1;
    t0 = cyc + 1;
    steps(8);
    check_int("release_delay", last_rel[0] - t0, D + 2);

    // Bounce: short lows never accepted.
    pc = press_cnt[0];
    for (int r = 0; r < 5; r++) begin
      btn_n[0] = 1'b0; steps(3);
      btn_n[0] = 1'b1; steps(3);
    end
    check_int("bounce_no_press", press_cnt[0], pc);
    check("bounce_pressed", pressed, 2'b00);

    // Release glitch while held: no release, long delayed by the glitch.
    rc = rel_cnt[0];
    lc = long_cnt[0];
    btn_n[0] = 1'b0;
    steps(7);
    t0 = last_press[0];
    steps(5);
    btn_n[0] = 1'b1; steps(2);
    btn_n[0] = 1'b0; steps(30);
    check_int("glitch_no_release", rel_cnt[0], rc);
    check_int("glitch_long_count", long_cnt[0], lc + 1);
    check_int("glitch_long_delay", last_long[0] - t0, L + 2);
    btn_n[0] = 1'b1;
    steps(10);

    // Simultaneous presses.
    btn_n = 2'b00;
    t0 = cyc + 1;
    steps(7);
    check_int("simul_press0", last_press[0], t0 + D + 2);
    check_int("simul_press1", last_press[1], t0 + D + 2);
    btn_n = 2'b11;
    steps(10);

    // Reset mid-hold: no release, fresh press after reset.
    btn_n[0] = 1'b0;
    steps(10);
    check("hold_before_reset", pressed, 2'b01);
    rc = rel_cnt[0];
    reset = 1'b1;
    step();
    check("reset_mid_hold", pressed | press_pulse | release_pulse | long_pulse, '0);
    reset = 1'b0;
    t0 = cyc + 1;
    steps(10);
    check_int("reset_no_release", rel_cnt[0], rc);
    check_int("repress_after_reset", last_press[0], t0 + D + 2);
    btn_n[0] = 1'b1;
    steps(10);

    // Randomized run: random hold lengths per button and occasional resets.
    for (int i = 0; i < N; i++) cnt[i] = $urandom_range(1, 30);
    for (int s = 0; s < 3000; s++) begin
      for (int i = 0; i < N; i++) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          btn_n[i] = ~btn_n[i];
          cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    btn_n = '1;
    steps(10);
    check("final_released", pressed, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
